multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Decode inputs and datapath control outputs of the controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [2:0] ALUControl;

  // Datapath side: supplies instruction fields and flags, consumes controls.
  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, ALUControl
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore FSM controller for a multicycle RV32 subset datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  wire logic             clk,
  input  wire logic             reset,
  multicycle_controller_if.slave ctl
);

  localparam logic [3:0] c_FETCH    = 4'd0;
  localparam logic [3:0] c_DECODE   = 4'd1;
  localparam logic [3:0] c_MEMADR   = 4'd2;
  localparam logic [3:0] c_MEMREAD  = 4'd3;
  localparam logic [3:0] c_MEMWB    = 4'd4;
  localparam logic [3:0] c_MEMWRITE = 4'd5;
  localparam logic [3:0] c_EXECR    = 4'd6;
  localparam logic [3:0] c_EXECI    = 4'd7;
  localparam logic [3:0] c_ALUWB    = 4'd8;
  localparam logic [3:0] c_BEQ      = 4'd9;
  localparam logic [3:0] c_JAL      = 4'd10;

  localparam logic [6:0] c_OP_LW    = 7'b0000011;
  localparam logic [6:0] c_OP_SW    = 7'b0100011;
  localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
  localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
  localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
  localparam logic [6:0] c_OP_JAL   = 7'b1101111;

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_branch;
  logic       w_pc_update;
  logic [2:0] w_alu_control;
  logic [1:0] w_imm_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = c_FETCH;
    case (r_state)
      c_FETCH:  w_next_state = c_DECODE;
      c_DECODE: begin
        case (ctl.op)
          c_OP_LW, c_OP_SW: w_next_state = c_MEMADR;
          c_OP_RTYPE:       w_next_state = c_EXECR;
          c_OP_ITYPE:       w_next_state = c_EXECI;
          c_OP_BEQ:         w_next_state = c_BEQ;
          c_OP_JAL:         w_next_state = c_JAL;
          default:          w_next_state = c_FETCH;
        endcase
      end
      c_MEMADR:   w_next_state = (ctl.op == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
      c_MEMREAD:  w_next_state = c_MEMWB;
      c_MEMWB:    w_next_state = c_FETCH;
      c_MEMWRITE: w_next_state = c_FETCH;
      c_EXECR:    w_next_state = c_ALUWB;
      c_EXECI:    w_next_state = c_ALUWB;
      c_ALUWB:    w_next_state = c_FETCH;
      c_BEQ:      w_next_state = c_FETCH;
      c_JAL:      w_next_state = c_ALUWB;
      default:    w_next_state = c_FETCH;
    endcase
  end

  always_comb begin
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    w_branch     = 1'b0;
    w_pc_update  = 1'b0;
    case (r_state)
      c_FETCH: begin
        w_ir_write   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_pc_update  = 1'b1;
      end
      c_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      c_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      c_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      c_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      c_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      c_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      c_ALUWB: begin
        w_reg_write = 1'b1;
      end
      c_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      c_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: begin
        w_adr_src = 1'b0;
      end
    endcase
  end

  // Subtract only for R-type SUB; I-type ADDI ignores bit 30 (op[5] = 0).
  always_comb begin
    w_alu_control = 3'b000;
    case (w_alu_op)
      2'b01: w_alu_control = 3'b001;
      2'b10: begin
        case (ctl.funct3)
          3'b000:  w_alu_control = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  w_alu_control = 3'b101;
          3'b110:  w_alu_control = 3'b011;
          3'b111:  w_alu_control = 3'b010;
          default: w_alu_control = 3'b000;
        endcase
      end
      default: w_alu_control = 3'b000;
    endcase
  end

  always_comb begin
    w_imm_src = 2'b00;
    case (ctl.op)
      c_OP_SW:  w_imm_src = 2'b01;
      c_OP_BEQ: w_imm_src = 2'b10;
      c_OP_JAL: w_imm_src = 2'b11;
      default:  w_imm_src = 2'b00;
    endcase
  end

  // Write enables are gated directly by the reset pin so they drop the
  // moment reset asserts, not at the next edge.
  assign ctl.PCWrite    = reset & (w_pc_update | (w_branch & ctl.zero));
  assign ctl.IRWrite    = reset & w_ir_write;
  assign ctl.MemWrite   = reset & w_mem_write;
  assign ctl.RegWrite   = reset & w_reg_write;
  assign ctl.AdrSrc     = w_adr_src;
  assign ctl.ResultSrc  = w_result_src;
  assign ctl.ALUSrcA    = w_alu_src_a;
  assign ctl.ALUSrcB    = w_alu_src_b;
  assign ctl.ImmSrc     = w_imm_src;
  assign ctl.ALUControl = w_alu_control;

endmodule

`default_nettype wire
